// File: rtl/sm4_key_expand.sv
// sm4_key_expand: SM4 round-key generator. Whitens the master key with FK,
// runs the key-mode round function once per cycle for 32 rounds, and serves
// the stored round keys by index in forward or reversed order.
// Optional build macro SM4_KEY_STREAM_EN adds a per-cycle stream of each
// round key as it is produced.
module sm4_key_expand #(
    parameter int word_width_p = 32,
    parameter int rounds_p     = 32
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    key_v_i,
    input  logic [4*word_width_p-1:0] key_i,
    output logic                    key_ready_o,
    output logic                    keys_v_o,
    input  logic [4:0]              rk_idx_i,
    input  logic                    decrypt_i,
    output logic [word_width_p-1:0] rk_o
`ifdef SM4_KEY_STREAM_EN
    ,
    output logic                    rk_stream_v_o,
    output logic [word_width_p-1:0] rk_stream_o,
    output logic [4:0]              rk_stream_idx_o
`endif
);

    typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

    localparam logic [7:0] sbox_c [256] = '{
        8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
        8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
        8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
        8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
        8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
        8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
        8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
        8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
        8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
        8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
        8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
        8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
        8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
        8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
        8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
        8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48
    };

    localparam logic [31:0] fk0_c = 32'hA3B1BAC6;
    localparam logic [31:0] fk1_c = 32'h56AA3350;
    localparam logic [31:0] fk2_c = 32'h677D9197;
    localparam logic [31:0] fk3_c = 32'hB27022DC;

    // Round function on state {X3,X2,X1,X0}: X0 ^ T(X1^X2^X3^rkey); key mode uses the lighter L'.
    function automatic logic [31:0] turn_transform(input logic [127:0] i,
                                                   input logic [31:0]  rkey,
                                                   input logic         is_key);
        logic [31:0] x;
        logic [31:0] b;
        logic [31:0] l;
        x = i[63:32] ^ i[95:64] ^ i[127:96] ^ rkey;
        b = {sbox_c[x[31:24]], sbox_c[x[23:16]], sbox_c[x[15:8]], sbox_c[x[7:0]]};
        if (is_key)
            l = b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
        else
            l = b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]} ^ {b[13:0], b[31:14]} ^ {b[7:0], b[31:8]};
        return i[31:0] ^ l;
    endfunction

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [127:0] k_q, k_d;
    logic [31:0] rk_buf_q [rounds_p];
    logic [31:0] rk_buf_d [rounds_p];
    logic [31:0] ck;
    logic [9:0]  ck_term;
    logic [31:0] nxt;
    logic        key_xfer;
    logic        last_round;

    assign key_xfer   = key_v_i & key_ready_o;
    assign last_round = (cnt_q == 5'(rounds_p - 1));

    // State register; reset returns to IDLE and abandons any partial expansion.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_q <= IDLE;
        else            state_q <= state_d;
    end

    // Next-state logic: start on a key transfer, finish on the round that writes the last key.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, READY: if (key_xfer) state_d = EXPAND;
            EXPAND:      if (last_round) state_d = READY;
            default:     state_d = IDLE;
        endcase
    end

    // FSM outputs: keys are valid exactly while in READY, which also covers the drop on rekey.
    always_comb begin
        key_ready_o = (state_q == IDLE) || (state_q == READY);
        keys_v_o    = (state_q == READY);
    end

    // CK bytes are ((4r+j)*7) mod 256 and the next round key is built from them.
    always_comb begin
        ck      = '0;
        ck_term = '0;
        for (int j = 0; j < 4; j++) begin
            ck_term = ((10'(cnt_q) << 2) + 10'(j)) * 10'd7;
            ck[31-8*j -: 8] = ck_term[7:0];
        end
        nxt = turn_transform(k_q, ck, 1'b1);
    end

    // Datapath next values: whitened load on transfer, one shift/write per EXPAND cycle.
    always_comb begin
        k_d      = k_q;
        cnt_d    = cnt_q;
        rk_buf_d = rk_buf_q;
        if (state_q == EXPAND) begin
            rk_buf_d[cnt_q] = nxt;
            k_d             = {nxt, k_q[127:32]};
            cnt_d           = cnt_q + 5'd1;
        end else if (key_xfer) begin
            k_d   = {key_i[31:0] ^ fk3_c, key_i[63:32] ^ fk2_c,
                     key_i[95:64] ^ fk1_c, key_i[127:96] ^ fk0_c};
            cnt_d = '0;
        end
    end

    // Datapath registers, cleared by reset so rk_o reads zero until a key is expanded.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            k_q   <= '0;
            cnt_q <= '0;
            for (int r = 0; r < rounds_p; r++) rk_buf_q[r] <= '0;
        end else begin
            k_q      <= k_d;
            cnt_q    <= cnt_d;
            rk_buf_q <= rk_buf_d;
        end
    end

    // Reversed order for decryption: 31-idx on a 5-bit index is its bitwise inverse.
    assign rk_o = rk_buf_q[decrypt_i ? ~rk_idx_i : rk_idx_i];

`ifdef SM4_KEY_STREAM_EN
    // Stream each round key in the cycle it is computed so a pipelined datapath can start early.
    always_comb begin
        rk_stream_v_o   = (state_q == EXPAND);
        rk_stream_o     = (state_q == EXPAND) ? nxt : '0;
        rk_stream_idx_o = (state_q == EXPAND) ? cnt_q : '0;
    end
`endif

endmodule

// File: tb/tb_sm4_key_expand.sv
// Testbench for sm4_key_expand: random and standard keys are issued, a reference
// model pushes the expected 32 round keys into a scoreboard, and a monitor sweeps
// rk_o in both orders whenever keys_v_o rises.
module tb_sm4_key_expand;

    typedef logic [31:0][31:0] rk_set_t;
    typedef struct packed {
        rk_set_t     rk;
        logic [31:0] xfer;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         key_v = 1'b0;
    logic [127:0] key = '0;
    logic [4:0]   rk_idx = '0;
    logic         decrypt = 1'b0;
    logic         key_ready;
    logic         keys_v;
    logic [31:0]  rk;
`ifdef SM4_KEY_STREAM_EN
    logic         rk_stream_v;
    logic [31:0]  rk_stream;
    logic [4:0]   rk_stream_idx;
`endif

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] cyc = '0;
    bit          aborted = 1'b0;
    bit          prev_keys_v = 1'b0;

    localparam logic [127:0] std_key = 128'h0123456789ABCDEFFEDCBA9876543210;

    byte unsigned sbox [256] = '{
        8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
        8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
        8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
        8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
        8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
        8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
        8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
        8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
        8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
        8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
        8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
        8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
        8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
        8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
        8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
        8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48
    };

    sm4_key_expand dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .key_v_i     (key_v),
        .key_i       (key),
        .key_ready_o (key_ready),
        .keys_v_o    (keys_v),
        .rk_idx_i    (rk_idx),
        .decrypt_i   (decrypt),
        .rk_o        (rk)
`ifdef SM4_KEY_STREAM_EN
        ,
        .rk_stream_v_o   (rk_stream_v),
        .rk_stream_o     (rk_stream),
        .rk_stream_idx_o (rk_stream_idx)
`endif
    );

    always #100 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 32'd1;

    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Reference key schedule: K[i+4] = K[i] ^ L'(S(K[i+1]^K[i+2]^K[i+3]^CK[i])), rk[i] = K[i+4].
    function automatic rk_set_t ref_keys(input logic [127:0] mk);
        logic [31:0] k [36];
        logic [31:0] fk [4];
        logic [31:0] ck, x, b;
        rk_set_t     res;
        fk[0] = 32'hA3B1BAC6; fk[1] = 32'h56AA3350; fk[2] = 32'h677D9197; fk[3] = 32'hB27022DC;
        for (int i = 0; i < 4; i++) k[i] = mk[127-32*i -: 32] ^ fk[i];
        for (int r = 0; r < 32; r++) begin
            ck = 0;
            for (int j = 0; j < 4; j++) ck = (ck << 8) | 32'(((4*r + j) * 7) % 256);
            x = k[r+1] ^ k[r+2] ^ k[r+3] ^ ck;
            for (int j = 0; j < 4; j++) b[31-8*j -: 8] = sbox[x[31-8*j -: 8]];
            k[r+4] = k[r] ^ b ^ rol(b, 13) ^ rol(b, 23);
            res[r] = k[r+4];
        end
        return res;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Issue one key from IDLE/READY; optionally keep key_v_i high with another key during EXPAND.
    task automatic applyStimulus(input logic [127:0] k, input bit busy);
        exp_t e;
        @(negedge clk);
        checkOutput("ready_before_xfer", 32'(key_ready), 32'd1);
        key_v = 1'b1;
        key   = k;
        @(negedge clk);
        e.rk   = ref_keys(k);
        e.xfer = cyc;
        sb.push_back(e);
        checkOutput("keys_v_after_xfer", 32'(keys_v), 32'd0);
        for (int n = 0; n < 32; n++) begin
            if (n > 0) @(negedge clk);
            checkOutput("ready_in_expand", 32'(key_ready), 32'd0);
            if (busy && n < 31) begin
                key_v = 1'b1;
                key   = ~k ^ 128'h5A;
            end else begin
                key_v = 1'b0;
            end
        end
        begin : wait_keys
            for (int w = 0; w < 4; w++) begin
                @(negedge clk);
                if (keys_v) disable wait_keys;
            end
            total++;
            bad++;
            $display("[TB] FAIL keys_v_timeout: got 0, expected 1 within 4 cycles");
        end
    endtask

    // Issue a key, then assert reset after ten rounds and check the outputs return to reset values.
    task automatic abortStimulus(input logic [127:0] k);
        exp_t e;
        @(negedge clk);
        key_v = 1'b1;
        key   = k;
        @(negedge clk);
        key_v  = 1'b0;
        e.rk   = ref_keys(k);
        e.xfer = cyc;
        sb.push_back(e);
        repeat (9) @(negedge clk);
        #10;
        aborted = 1'b1;
        reset_n = 1'b0;
        void'(sb.pop_back());
        #1;
        checkOutput("reset_rk", rk, 32'd0);
        checkOutput("reset_keys_v", 32'(keys_v), 32'd0);
        checkOutput("reset_ready", 32'(key_ready), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Monitor: on each rising keys_v_o, pop the expected set and sweep both read orders.
    initial begin
        forever begin
            @(negedge clk);
            if (keys_v && !prev_keys_v) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_keys_v: got 1, expected 0 with empty scoreboard");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("latency", cyc - e.xfer, 32'd32);
                    for (int i = 0; i < 32; i++) begin
                        rk_idx  = 5'(i);
                        decrypt = 1'b0;
                        #1;
                        checkOutput("rk_fwd", rk, e.rk[i]);
                        decrypt = 1'b1;
                        #1;
                        checkOutput("rk_rev", rk, e.rk[31-i]);
                    end
                end
            end
            prev_keys_v = keys_v;
        end
    end

`ifdef SM4_KEY_STREAM_EN
    int run = 0;
    // Stream monitor: indices step 0..31, values match the expected set, run length is 32.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rk_stream_v) begin
                checkOutput("stream_idx", 32'(rk_stream_idx), 32'(run));
                if (sb.size() > 0 && run < 32) checkOutput("stream_val", rk_stream, sb[$].rk[run]);
                run++;
            end else begin
                if (run != 0 && !aborted) checkOutput("stream_len", 32'(run), 32'd32);
                if (run != 0) aborted = 1'b0;
                run = 0;
            end
        end
    end
`endif

    initial begin
        #4000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: reset state, standard vector with busy key, rekeys, mid-expansion reset.
    initial begin
        rk_set_t m;
        m = ref_keys(std_key);
        checkOutput("model_rk0", m[0], 32'hF12186F9);
        checkOutput("model_rk1", m[1], 32'h41662B61);
        checkOutput("model_rk31", m[31], 32'h9124A012);
        repeat (3) @(negedge clk);
        checkOutput("init_keys_v", 32'(keys_v), 32'd0);
        checkOutput("init_ready", 32'(key_ready), 32'd1);
        checkOutput("init_rk", rk, 32'd0);
        reset_n = 1'b1;
        applyStimulus(std_key, 1'b1);
        applyStimulus('0, 1'b0);
        for (int t = 0; t < 2; t++)
            applyStimulus({$urandom, $urandom, $urandom, $urandom}, t[0]);
        abortStimulus({$urandom, $urandom, $urandom, $urandom});
        applyStimulus(std_key, 1'b0);
        for (int t = 0; t < 2; t++)
            applyStimulus({$urandom, $urandom, $urandom, $urandom}, 1'b1);
        repeat (4) @(negedge clk);
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sm4_key_expand.md
# sm4_key_expand

Round-key generator for the SM4 encryptor. Accepts a 128-bit master key, applies the FK whitening, and iterates the key-mode round function (one `turn_transform` with `is_key_i=1`) once per cycle for 32 rounds. Stores the 32 round keys in a register buffer and serves them by round index, in forward or reversed order, as `rkey_i` to the content-round datapath.

## Interface
Parameters:
- `word_width_p`, 32: word width; fixed by SM4.
- `rounds_p`, 32: number of rounds and buffer depth.

Ports:
- `clk_i`  in  1  clock.
- `reset_n_i`  in  1  asynchronous, active-low reset.
- `key_v_i`  in  1  master key valid.
- `key_i`  in  128  master key; MK0 = `key_i[127:96]`.
- `key_ready_o`  out  1  high in IDLE or READY. A key transfers when `key_v_i & key_ready_o`.
- `keys_v_o`  out  1  all 32 round keys are valid.
- `rk_idx_i`  in  5  round index requested by the datapath.
- `decrypt_i`  in  1  1 selects reversed order.
- `rk_o`  out  32  `buf[decrypt_i ? 31-rk_idx_i : rk_idx_i]`; combinational read.

## Operation
- FSM states:
  - IDLE: entered at reset.
  - EXPAND: round generation.
  - READY: keys valid.
- IDLE/READY on key transfer → EXPAND:
  - load K = {MK3^FK3, MK2^FK2, MK1^FK1, MK0^FK0}, with K0 in the low word.
  - round counter `cnt` = 0.
  - `keys_v_o` = 0.
- FK constants: A3B1BAC6, 56AA3350, 677D9197, B27022DC.
- EXPAND, each cycle:
  - compute nxt = K0 ^ T'(K1^K2^K3^CK[cnt]) using `turn_transform` with `i`={K3,K2,K1,K0}, `rkey_i`=CK[cnt], `is_key_i`=1, `mask_i`='0.
  - at the clock edge: `buf[cnt]`=nxt; K={nxt,K3,K2,K1}; `cnt`++.
- EXPAND → READY on the edge that writes `buf[31]`; `keys_v_o` is set on that same edge.
- CK[r] byte j (MSB first) = ((4r+j)·7) mod 256, computed on the fly from `cnt`. Examples: CK0=00070E15, CK1=1C232A31.
- `key_ready_o` = 0 in EXPAND. `key_v_i` is ignored there; an in-flight expansion is never aborted.
- Key transfer in READY: buffer contents stay readable but `keys_v_o` drops on the transfer edge. The datapath must not consume `rk_o` while `keys_v_o`=0.
- `rk_idx_i` and `decrypt_i` may change every cycle and have no effect on expansion.

## Timing
- Reset (async assert, sync-safe deassert):
  - state=IDLE, `cnt`=0, `buf`=all zero, K=0.
  - hence `keys_v_o`=0, `key_ready_o`=1, `rk_o`=0.
- Latency: a transfer on edge E0 gives `buf[r]` written on edge E0+r+1, and `keys_v_o`=1 after edge E0+32.
- Throughput: one key per 33 cycles when keys are issued back-to-back from READY.
- Reset asserted mid-EXPAND: immediate return to reset values; the partial keys are discarded.
- `rk_o` has zero-cycle latency from `rk_idx_i`/`decrypt_i`. Any index 0..31 is legal; there is no out-of-range case.

## Configuration
- `SM4_KEY_STREAM_EN` defined: adds the ports below.
  - `rk_stream_v_o` (out, 1): pulses high each EXPAND cycle.
  - `rk_stream_o` (out, 32): equals nxt.
  - `rk_stream_idx_o` (out, 5): equals `cnt`.
  - Purpose: a pipelined datapath can start encrypting during expansion.
  - Reset values: all 0.
- Undefined: these ports do not exist. Round keys are reachable only through `rk_o` after `keys_v_o`.

## Test plan
- Standard vector:
  - stimulus: `key_i`=0123456789ABCDEFFEDCBA9876543210.
  - required: `keys_v_o` rises exactly 32 cycles after transfer; `rk_idx_i`=0 → F12186F9; `rk_idx_i`=1 → 41662B61; `rk_idx_i`=31 → 9124A012.
- Decrypt order: after the standard vector, `decrypt_i`=1 with `rk_idx_i`=0 → 9124A012, with `rk_idx_i`=31 → F12186F9.
- Busy ignore:
  - stimulus: `key_v_i` held high with a different key during EXPAND.
  - required: `key_ready_o`=0 throughout; the result matches the first key only.
- Rekey from READY:
  - stimulus: new all-zero key transferred.
  - required: `keys_v_o` falls on that edge and rises 32 cycles later; `buf[0]` matches the golden model.
- Mid-expansion reset:
  - stimulus: assert `reset_n_i` at round 10.
  - required: `rk_o`=0, `keys_v_o`=0, `key_ready_o`=1 immediately; a subsequent full expansion is correct.
- `SM4_KEY_STREAM_EN` build:
  - required: `rk_stream_v_o` high for exactly 32 consecutive cycles; `rk_stream_idx_o` steps 0..31; the streamed values equal the buffer contents.
